// File: rtl/uart_frame_parser_pkg.sv
// uart_frame_parser_pkg: constants shared by the UART parser slice.
// The receiver and transmitter use the same bit timing and byte width.
// The CSUM state exists only when UART_PARSER_CHECKSUM_EN is defined.
package uart_frame_parser_pkg;

  // One bit lasts BPS_MAX clk cycles. A byte is BIT_MAX data bits.
  localparam int BPS_MAX = 5208;
  localparam int BIT_MAX = 8;

  // Default sync bytes that open every frame.
  localparam logic [7:0] HDR0_DEFAULT = 8'h55;
  localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

  // Parser state encodings. The 3-bit width matches the other UART blocks.
  localparam logic [2:0] ST_HUNT0   = 3'd0;
  localparam logic [2:0] ST_HUNT1   = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
`ifdef UART_PARSER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM    = 3'd4;
`endif

endpackage

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if: byte stream from the UART receiver into the parser,
// and the framed payload/status stream out of it.
// master = the side that feeds bytes and consumes payload; slave = the parser.
interface uart_frame_parser_if
  import uart_frame_parser_pkg::*;
#(
  parameter int DATA_W = BIT_MAX
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic [DATA_W-1:0] payload_data;
  logic              payload_valid;
  logic [7:0]        frame_len;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output rx_data,
    output rx_ready,
    input  payload_data,
    input  payload_valid,
    input  frame_len,
    input  frame_done,
    input  frame_err
  );

  modport slave (
    input  rx_data,
    input  rx_ready,
    output payload_data,
    output payload_valid,
    output frame_len,
    output frame_done,
    output frame_err
  );

endinterface

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe: turns the receiver's level-style rx_ready into a
// single-cycle strobe on its rising edge and presents the byte in that cycle.
// Other consumers of the receiver also use this block, so it holds no framing logic.
module uart_byte_strobe
  import uart_frame_parser_pkg::*;
#(
  parameter int DATA_W = BIT_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rxData_i,
  input  logic              rxReady_i,
  output logic              stb_o,
  output logic [DATA_W-1:0] byte_o
);

  logic rxReady_q;

  // Keep last cycle's rx_ready so a long level yields a single strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxReady_q <= 1'b0;
    end else begin
      rxReady_q <= rxReady_i;
    end
  end

  assign stb_o  = rxReady_i & ~rxReady_q;
  assign byte_o = stb_o ? rxData_i : '0;

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: finds HDR0 HDR1 LEN payload [checksum] frames in the
// UART byte stream. Payload bytes stream out as they arrive. One done or error
// pulse ends each frame. All outputs are registered, one cycle after the strobe.
// Build option: define UART_PARSER_CHECKSUM_EN to require a trailing checksum
// byte equal to (LEN + payload) mod 256.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int                DATA_W      = BIT_MAX,
  parameter logic [DATA_W-1:0] HDR0        = DATA_W'(HDR0_DEFAULT),
  parameter logic [DATA_W-1:0] HDR1        = DATA_W'(HDR1_DEFAULT),
  parameter int                MAX_LEN     = 16,
  parameter int                TIMEOUT_CYC = 10 * BPS_MAX
) (
  input  logic               clk,
  input  logic               rst,
  uart_frame_parser_if.slave bus
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] MAX_LEN_W = DATA_W'(MAX_LEN);

  logic              stb;
  logic [DATA_W-1:0] rxByte;

  logic [2:0]        state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;
  logic [7:0]        frameLen_q, frameLen_d;
  logic [DATA_W-1:0] payloadData_q, payloadData_d;
  logic              payloadValid_q, payloadValid_d;
  logic              frameDone_q, frameDone_d;
  logic              frameErr_q, frameErr_d;
`ifdef UART_PARSER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  uart_byte_strobe #(
    .DATA_W (DATA_W)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .rxData_i  (bus.rx_data),
    .rxReady_i (bus.rx_ready),
    .stb_o     (stb),
    .byte_o    (rxByte)
  );

  // Next-state logic. A strobe always advances the parser and restarts the
  // idle count. Otherwise, inside a frame, the idle count runs toward timeout.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    idleCnt_d      = idleCnt_q;
    frameLen_d     = frameLen_q;
    payloadData_d  = payloadData_q;
    payloadValid_d = 1'b0;
    frameDone_d    = 1'b0;
    frameErr_d     = 1'b0;
`ifdef UART_PARSER_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    if (stb) begin
      idleCnt_d = '0;
      case (state_q)
        ST_HUNT0: begin
          if (rxByte == HDR0) begin
            state_d = ST_HUNT1;
          end
        end
        ST_HUNT1: begin
          if (rxByte == HDR1) begin
            state_d = ST_LEN;
          end else if (rxByte != HDR0) begin
            state_d = ST_HUNT0;
          end
        end
        ST_LEN: begin
          frameLen_d = 8'(rxByte);
          idx_d      = '0;
`ifdef UART_PARSER_CHECKSUM_EN
          sum_d      = 8'(rxByte);
`endif
          if (rxByte > MAX_LEN_W) begin
            frameErr_d = 1'b1;
            state_d    = ST_HUNT0;
          end else if (rxByte == '0) begin
`ifdef UART_PARSER_CHECKSUM_EN
            state_d     = ST_CSUM;
`else
            frameDone_d = 1'b1;
            state_d     = ST_HUNT0;
`endif
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          payloadData_d  = rxByte;
          payloadValid_d = 1'b1;
          idx_d          = idx_q + 8'd1;
`ifdef UART_PARSER_CHECKSUM_EN
          sum_d          = sum_q + 8'(rxByte);
`endif
          if (idx_q == frameLen_q - 8'd1) begin
`ifdef UART_PARSER_CHECKSUM_EN
            state_d     = ST_CSUM;
`else
            frameDone_d = 1'b1;
            state_d     = ST_HUNT0;
`endif
          end
        end
`ifdef UART_PARSER_CHECKSUM_EN
        ST_CSUM: begin
          if (8'(rxByte) == sum_q) begin
            frameDone_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
          state_d = ST_HUNT0;
        end
`endif
        default: begin
          state_d = ST_HUNT0;
        end
      endcase
    end else if (state_q != ST_HUNT0) begin
      if (idleCnt_q == IDLE_LAST) begin
        frameErr_d = 1'b1;
        state_d    = ST_HUNT0;
        idleCnt_d  = '0;
      end else begin
        idleCnt_d = idleCnt_q + 1'b1;
      end
    end
  end

  // State, counters and registered outputs. Reset drops any partial frame silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_HUNT0;
      idx_q          <= '0;
      idleCnt_q      <= '0;
      frameLen_q     <= '0;
      payloadData_q  <= '0;
      payloadValid_q <= 1'b0;
      frameDone_q    <= 1'b0;
      frameErr_q     <= 1'b0;
`ifdef UART_PARSER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      idleCnt_q      <= idleCnt_d;
      frameLen_q     <= frameLen_d;
      payloadData_q  <= payloadData_d;
      payloadValid_q <= payloadValid_d;
      frameDone_q    <= frameDone_d;
      frameErr_q     <= frameErr_d;
`ifdef UART_PARSER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign bus.payload_data  = payloadData_q;
  assign bus.payload_valid = payloadValid_q;
  assign bus.frame_len     = frameLen_q;
  assign bus.frame_done    = frameDone_q;
  assign bus.frame_err     = frameErr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: drives directed and random byte streams into
// uart_frame_parser. A frame-level reference model predicts every output
// each cycle. Directed frames also check hand-computed payload/done/error counts.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 6000;
`ifdef UART_PARSER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef logic [7:0] byteQ_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_frame_parser_if #(.DATA_W(8)) bus ();

  uart_frame_parser #(
    .DATA_W      (8),
    .HDR0        (8'h55),
    .HDR1        (8'hAA),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Model state: bytes of the frame being collected (empty = hunting).
  logic [7:0] frameQ[$];
  int         idle = 0;
  logic       prevReady = 1'b0;
  logic [7:0] expPayloadData = 8'h00;
  logic       expPayloadValid = 1'b0;
  logic [7:0] expFrameLen = 8'h00;
  logic       expFrameDone = 1'b0;
  logic       expFrameErr = 1'b0;

  // Monitor logs for directed checks.
  logic [7:0] seenPay[$];
  int         doneCnt = 0;
  int         errCnt  = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Feed one byte into the frame-level model.
  task automatic modelByte(input logic [7:0] b);
    int n;
    int len;
    int s;
    n = frameQ.size();
    if (n == 0) begin
      if (b == 8'h55) frameQ.push_back(b);
    end else if (n == 1) begin
      if (b == 8'hAA) frameQ.push_back(b);
      else if (b != 8'h55) frameQ.delete();
    end else if (n == 2) begin
      expFrameLen = b;
      if (int'(b) > MAX_LEN) begin
        expFrameErr = 1'b1;
        frameQ.delete();
      end else if (b == 8'h00 && !CSUM_EN) begin
        expFrameDone = 1'b1;
        frameQ.delete();
      end else begin
        frameQ.push_back(b);
      end
    end else begin
      len = int'(frameQ[2]);
      if (n - 3 < len) begin
        expPayloadData  = b;
        expPayloadValid = 1'b1;
        frameQ.push_back(b);
        if (n - 2 == len && !CSUM_EN) begin
          expFrameDone = 1'b1;
          frameQ.delete();
        end
      end else begin
        s = 0;
        for (int i = 2; i < n; i++) s += int'(frameQ[i]);
        if ((s % 256) == int'(b)) expFrameDone = 1'b1;
        else expFrameErr = 1'b1;
        frameQ.delete();
      end
    end
  endtask

  // Reference model: at each edge, derive what the registered outputs must become.
  always @(posedge clk) begin : model
    bit stbNow;
    expPayloadValid = 1'b0;
    expFrameDone    = 1'b0;
    expFrameErr     = 1'b0;
    if (!rst) begin
      frameQ.delete();
      idle           = 0;
      prevReady      = 1'b0;
      expPayloadData = 8'h00;
      expFrameLen    = 8'h00;
    end else begin
      stbNow    = bus.rx_ready && !prevReady;
      prevReady = bus.rx_ready;
      if (stbNow) begin
        idle = 0;
        modelByte(bus.rx_data);
      end else if (frameQ.size() > 0) begin
        idle++;
        if (idle >= TO) begin
          expFrameErr = 1'b1;
          frameQ.delete();
          idle = 0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge; reset forces all outputs to zero.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rstPayloadData", int'(bus.payload_data), 0);
      checkOutput("rstPayloadValid", int'(bus.payload_valid), 0);
      checkOutput("rstFrameLen", int'(bus.frame_len), 0);
      checkOutput("rstFrameDone", int'(bus.frame_done), 0);
      checkOutput("rstFrameErr", int'(bus.frame_err), 0);
    end else begin
      checkOutput("payloadData", int'(bus.payload_data), int'(expPayloadData));
      checkOutput("payloadValid", int'(bus.payload_valid), int'(expPayloadValid));
      checkOutput("frameLen", int'(bus.frame_len), int'(expFrameLen));
      checkOutput("frameDone", int'(bus.frame_done), int'(expFrameDone));
      checkOutput("frameErr", int'(bus.frame_err), int'(expFrameErr));
      if (bus.payload_valid === 1'b1) seenPay.push_back(bus.payload_data);
      if (bus.frame_done === 1'b1) doneCnt++;
      if (bus.frame_err === 1'b1) errCnt++;
    end
  end

  // Present one byte for 'hi' cycles, then drop rx_ready for 'lo' cycles.
  task automatic applyStimulus(input logic [7:0] b, input int hi, input int lo);
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    repeat (hi) begin @(posedge clk); #2; end
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (lo) begin @(posedge clk); #2; end
  endtask

  task automatic sendBytes(input byteQ_t bytes);
    foreach (bytes[i]) applyStimulus(bytes[i], 2, 2);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clearLogs();
    seenPay.delete();
    doneCnt = 0;
    errCnt  = 0;
  endtask

  function automatic logic [7:0] frameSum(input byteQ_t bytes);
    int s;
    s = 0;
    foreach (bytes[i]) s += int'(bytes[i]);
    return 8'(s);
  endfunction

  initial begin
    byteQ_t fr;
    byteQ_t pl;
    int kind;
    int len;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    rst          = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetFrameLen", int'(bus.frame_len), 0);
    checkOutput("resetPayloadValid", int'(bus.payload_valid), 0);
    rst = 1'b1;
    waitCycles(2);

    // Good frame
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    waitCycles(3);
    checkOutput("goodPayCount", seenPay.size(), 3);
    if (seenPay.size() == 3) begin
      checkOutput("goodPay0", int'(seenPay[0]), 'h11);
      checkOutput("goodPay1", int'(seenPay[1]), 'h22);
      checkOutput("goodPay2", int'(seenPay[2]), 'h33);
    end
    checkOutput("goodLen", int'(bus.frame_len), 3);
    checkOutput("goodDone", doneCnt, 1);
    checkOutput("goodErr", errCnt, 0);

    // Bad checksum
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00});
    waitCycles(3);
    checkOutput("badCsumPayCount", seenPay.size(), 2);
    checkOutput("badCsumDone", doneCnt, CSUM_EN ? 0 : 1);
    checkOutput("badCsumErr", errCnt, CSUM_EN ? 1 : 0);

    // Oversize LEN, then an empty frame
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h20});
    checkOutput("oversizeErr", errCnt, 1);
    sendBytes('{8'h55, 8'hAA, 8'h00, 8'h00});
    waitCycles(3);
    checkOutput("emptyDone", doneCnt, 1);
    checkOutput("emptyErr", errCnt, 1);
    checkOutput("emptyLen", int'(bus.frame_len), 0);

    // Resync on a repeated HDR0
    clearLogs();
    sendBytes('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F});
    waitCycles(3);
    checkOutput("resyncPayCount", seenPay.size(), 1);
    if (seenPay.size() == 1) checkOutput("resyncPay0", int'(seenPay[0]), 'h7E);
    checkOutput("resyncDone", doneCnt, 1);

    // Timeout inside a frame, then a normal frame
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h04, 8'h10});
    waitCycles(TO + 10);
    checkOutput("timeoutErr", errCnt, 1);
    checkOutput("timeoutDone", doneCnt, 0);
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    waitCycles(3);
    checkOutput("afterTimeoutDone", doneCnt, 1);
    checkOutput("afterTimeoutErr", errCnt, 1);

    // Long rx_ready level gives one strobe only
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h01});
    applyStimulus(8'h7E, 5208, 3);
    sendBytes('{8'h7F});
    waitCycles(3);
    checkOutput("levelPayCount", seenPay.size(), 1);
    checkOutput("levelDone", doneCnt, 1);
    checkOutput("levelErr", errCnt, 0);

    // Reset mid-payload discards the frame without a pulse
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11});
    rst = 1'b0;
    waitCycles(1);
    checkOutput("midRstLen", int'(bus.frame_len), 0);
    checkOutput("midRstData", int'(bus.payload_data), 0);
    waitCycles(2);
    rst = 1'b1;
    waitCycles(2);
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    waitCycles(3);
    checkOutput("midRstPayCount", seenPay.size(), 4);
    checkOutput("midRstDone", doneCnt, 1);
    checkOutput("midRstErr", errCnt, 0);

    // Random traffic against the model
    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(0, MAX_LEN);
      pl.delete();
      pl.push_back(8'(len));
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      fr.delete();
      if (kind == 0) begin
        for (int i = 0; i < $urandom_range(1, 4); i++)
          fr.push_back(($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom_range(0, 255)));
      end else if (kind == 1) begin
        fr = '{8'h55, 8'hAA, 8'($urandom_range(MAX_LEN + 1, 255))};
      end else begin
        fr = '{8'h55, 8'hAA};
        foreach (pl[i]) fr.push_back(pl[i]);
        if (kind == 2) fr.push_back(frameSum(pl) ^ 8'($urandom_range(1, 255)));
        else fr.push_back(frameSum(pl));
      end
      if (f == 60 || f == 130) begin
        fr = '{8'h55, 8'hAA, 8'h05, 8'h01};
        sendBytes(fr);
        waitCycles(TO + 5);
      end else begin
        foreach (fr[i]) applyStimulus(fr[i], $urandom_range(1, 4), $urandom_range(1, 4));
      end
    end
    waitCycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
